// File: rtl/shift_add_sequencer_pkg.sv
// Shared constants and state encoding for the shift-and-add multiplier sequencer.
// Compile before the interface, the counter and the top.
package shift_add_sequencer_pkg;
  localparam int NBits     = 8;
  localparam int SEQ_CNT_W = $clog2(NBits + 1);

  typedef enum logic [2:0] {IDLE, LOAD, ADD, SHIFT, DONE} seq_state_t;
endpackage

// File: rtl/shift_add_sequencer_if.sv
// Request handshake plus datapath control bundle between the sequencer and its users.
// master = requester/datapath side; slave = the sequencer itself.
interface shift_add_sequencer_if #(
  parameter int CNT_W = shift_add_sequencer_pkg::SEQ_CNT_W
);
  logic             req;
  logic             abort;
  logic             multiplier_lsb;
  logic             ready;
  logic             busy;
  logic             load;
  logic             adder_clear;
  logic             add_en;
  logic             shift_en;
  logic             ef;
  logic             done;
  logic [CNT_W-1:0] bit_count;

  modport master (
    output req, abort, multiplier_lsb,
    input  ready, busy, load, adder_clear, add_en, shift_en, ef, done, bit_count
  );

  modport slave (
    input  req, abort, multiplier_lsb,
    output ready, busy, load, adder_clear, add_en, shift_en, ef, done, bit_count
  );
endinterface

// File: rtl/shift_add_sequencer_seq_bit_counter.sv
// Iteration counter: synchronous clear, increment saturating at NBITS, terminal flag at NBITS-1.
// Count updates one cycle after clear/inc; there is no backpressure.
module seq_bit_counter
  import shift_add_sequencer_pkg::*;
#(
  parameter int NBITS = NBits,
  parameter int CNT_W = $clog2(NBITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             terminal
);
  localparam logic [CNT_W-1:0] CntMax  = CNT_W'(NBITS);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(NBITS - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != CntMax)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign terminal = (count == CntLast);
endmodule

// File: rtl/shift_add_sequencer.sv
// Shift-and-add multiplier control FSM: LOAD, NBITS x (ADD, SHIFT), DONE; done 2*NBITS+2 cycles after req.
// Requests are accepted only while ready (IDLE); req during an operation is dropped, not queued.
module shift_add_sequencer
  import shift_add_sequencer_pkg::*;
#(
  parameter int NBITS = NBits,
  parameter int CNT_W = $clog2(NBITS + 1)
) (
  input logic                  clk,
  input logic                  rst,
  shift_add_sequencer_if.slave bus
);
  seq_state_t       state;
  seq_state_t       state_nxt;
  logic             cnt_clear;
  logic             cnt_inc;
  logic             cnt_last;
  logic [CNT_W-1:0] cnt;

  seq_bit_counter #(
    .NBITS(NBITS),
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (cnt_clear),
    .inc     (cnt_inc),
    .count   (cnt),
    .terminal(cnt_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ef defaults high so IDLE, DONE and any illegal encoding keep the accumulator frozen.
  always_comb begin
    state_nxt       = IDLE;
    cnt_clear       = 1'b0;
    cnt_inc         = 1'b0;
    bus.ready       = 1'b0;
    bus.busy        = 1'b0;
    bus.load        = 1'b0;
    bus.adder_clear = 1'b0;
    bus.add_en      = 1'b0;
    bus.shift_en    = 1'b0;
    bus.ef          = 1'b1;
    bus.done        = 1'b0;
    case (state)
      IDLE: begin
        bus.ready = 1'b1;
        if (bus.req) begin
          state_nxt = LOAD;
          cnt_clear = 1'b1;
        end
      end
      LOAD: begin
        bus.busy        = 1'b1;
        bus.load        = 1'b1;
        bus.adder_clear = 1'b1;
        bus.ef          = 1'b0;
        state_nxt       = bus.abort ? IDLE : ADD;
      end
      ADD: begin
        bus.busy   = 1'b1;
        bus.add_en = bus.multiplier_lsb;
        bus.ef     = 1'b0;
        state_nxt  = bus.abort ? IDLE : SHIFT;
      end
      SHIFT: begin
        bus.busy     = 1'b1;
        bus.shift_en = 1'b1;
        bus.ef       = 1'b0;
        cnt_inc      = 1'b1;
        if (bus.abort) begin
          state_nxt = IDLE;
        end else if (cnt_last) begin
          state_nxt = DONE;
        end else begin
          state_nxt = ADD;
        end
      end
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.bit_count = cnt;
endmodule
